// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Brief    : Two-stage pipelined carry-lookahead adder/subtractor with
//            saturating, wrapping and packed-lane (PADDSB) modes, Z/V/N flags
//            and valid/ready flow control on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic             z_out,
    output logic             v_out,
    output logic             n_out
);

    localparam int         c_NG      = WIDTH / GROUP;
    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_PADD = 2'b10;
    localparam logic [1:0] c_OP_WRAP = 2'b11;

    localparam logic [WIDTH-1:0] c_WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [GROUP-1:0] c_LANE_MAX = {1'b0, {(GROUP-1){1'b1}}};
    localparam logic [GROUP-1:0] c_LANE_MIN = {1'b1, {(GROUP-1){1'b0}}};

    generate
        if (((WIDTH % GROUP) != 0) || (WIDTH < 8)) begin : g_bad_params
            $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and >= 8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_en;
    logic w_s1_en;

    assign w_s2_en   = !r_out_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning, bit and group propagate/generate
    // ------------------------------------------------------------------
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [c_NG-1:0]  w_gp;
    logic [c_NG-1:0]  w_gg;
    logic [c_NG-1:0]  w_a_sign;

    assign w_sub   = (op_in == c_OP_SUB);
    assign w_b_eff = w_sub ? ~b_in : b_in;
    assign w_p     = a_in ^ w_b_eff;
    assign w_g     = a_in & w_b_eff;

    always_comb begin : p_group_pg
        logic v_gp;
        logic v_gg;
        w_gp     = '0;
        w_gg     = '0;
        w_a_sign = '0;
        for (int k = 0; k < c_NG; k++) begin
            v_gp = 1'b1;
            v_gg = 1'b0;
            for (int j = 0; j < GROUP; j++) begin
                v_gg = w_g[k*GROUP+j] | (w_p[k*GROUP+j] & v_gg);
                v_gp = v_gp & w_p[k*GROUP+j];
            end
            w_gp[k]     = v_gp;
            w_gg[k]     = v_gg;
            w_a_sign[k] = a_in[k*GROUP+GROUP-1];
        end
    end

    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [c_NG-1:0]  r_gp;
    logic [c_NG-1:0]  r_gg;
    logic [c_NG-1:0]  r_a_sign;
    logic             r_c0;
    logic [1:0]       r_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_gp       <= '0;
            r_gg       <= '0;
            r_a_sign   <= '0;
            r_c0       <= 1'b0;
            r_op       <= c_OP_ADD;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_p      <= w_p;
                r_g      <= w_g;
                r_gp     <= w_gp;
                r_gg     <= w_gg;
                r_a_sign <= w_a_sign;
                r_c0     <= w_sub;
                r_op     <= op_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: group carries, in-group lookahead, overflow, saturation
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_res;
    logic             w_v;

    always_comb begin : p_stage2
        logic             v_padd;
        logic             v_carry;
        logic             v_acc;
        logic             v_prod;
        logic             v_co;
        logic [c_NG-1:0]  v_lane_cin;
        logic [c_NG-1:0]  v_ovf;
        logic [WIDTH-1:0] v_c;
        logic [WIDTH-1:0] v_sum;

        v_padd     = (r_op == c_OP_PADD);
        v_carry    = r_c0;
        v_lane_cin = '0;
        v_ovf      = '0;
        v_c        = '0;
        w_res      = '0;
        w_v        = 1'b0;

        // Cross-group lookahead; PADDSB isolates every lane.
        for (int k = 0; k < c_NG; k++) begin
            v_lane_cin[k] = v_padd ? 1'b0 : v_carry;
            v_carry       = r_gg[k] | (r_gp[k] & v_carry);
        end

        // Carry into each bit expanded from its lane carry-in.
        for (int k = 0; k < c_NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                v_acc  = 1'b0;
                v_prod = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    v_acc  = v_acc | (v_prod & r_g[k*GROUP+m]);
                    v_prod = v_prod & r_p[k*GROUP+m];
                end
                v_c[k*GROUP+j] = v_acc | (v_prod & v_lane_cin[k]);
            end
            v_co     = r_g[k*GROUP+GROUP-1] | (r_p[k*GROUP+GROUP-1] & v_c[k*GROUP+GROUP-1]);
            v_ovf[k] = v_c[k*GROUP+GROUP-1] ^ v_co;
        end

        v_sum = r_p ^ v_c;
        w_res = v_sum;

        if (v_padd) begin
            w_v = |v_ovf;
            for (int k = 0; k < c_NG; k++) begin
                if (v_ovf[k]) begin
                    w_res[k*GROUP +: GROUP] = r_a_sign[k] ? c_LANE_MIN : c_LANE_MAX;
                end
            end
        end else begin
            w_v = v_ovf[c_NG-1];
            if (v_ovf[c_NG-1] && (r_op != c_OP_WRAP)) begin
                w_res = r_a_sign[c_NG-1] ? c_WORD_MIN : c_WORD_MAX;
            end
        end
    end

    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_v;
    logic             r_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_z      <= (w_res == '0);
                r_v      <= w_v;
                r_n      <= w_res[WIDTH-1];
            end
        end
    end

    assign result_out = r_result;
    assign z_out      = r_z;
    assign v_out      = r_v;
    assign n_out      = r_n;

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_addsub_pipe
// Brief    : Directed self-checking bench for cla_addsub_pipe (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [1:0]  op_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_out;
    logic        z_out;
    logic        v_out;
    logic        n_out;

    int tests = 0;
    int fails = 0;

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .z_out      (z_out),
        .v_out      (v_out),
        .n_out      (n_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {v, result} from plain integer arithmetic.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
        int          s;
        int          la;
        int          lb;
        logic        v;
        logic [15:0] r;
        v = 1'b0;
        r = '0;
        if (op == 2'b10) begin
            for (int l = 0; l < 4; l++) begin
                la = int'($signed(a[4*l +: 4]));
                lb = int'($signed(b[4*l +: 4]));
                s  = la + lb;
                if (s > 7) begin
                    r[4*l +: 4] = 4'h7; v = 1'b1;
                end else if (s < -8) begin
                    r[4*l +: 4] = 4'h8; v = 1'b1;
                end else begin
                    r[4*l +: 4] = s[3:0];
                end
            end
        end else begin
            s = (op == 2'b01) ? int'($signed(a)) - int'($signed(b))
                              : int'($signed(a)) + int'($signed(b));
            v = (s > 32767) || (s < -32768);
            r = s[15:0];
            if (op != 2'b11 && s > 32767)  r = 16'h7FFF;
            if (op != 2'b11 && s < -32768) r = 16'h8000;
        end
        return {v, r};
    endfunction

    // Single op through an idle pipe; entered and left at posedge+1.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] er, input logic ev,
                         input logic en, input logic ez);
        a_in = a; b_in = b; op_in = op; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"},   32'(result_out), 32'(er));
        check({tag, "_v"},     32'(v_out), 32'(ev));
        check({tag, "_n"},     32'(n_out), 32'(en));
        check({tag, "_z"},     32'(z_out), 32'(ez));
        @(posedge clk);
        #1;
    endtask

    logic [15:0] va[6];
    logic [15:0] vb[6];
    logic [1:0]  vop[6];
    logic [16:0] expq[$];
    logic [16:0] e;

    initial begin
        int          sent;
        int          recv;
        int          max_inflight;
        bit          saw_low;
        bit          prev_stall;
        logic [15:0] prev_res;
        logic [2:0]  prev_flags;
        bit          acc;
        bit          xfer;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; op_in = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result_out), 32'd0);
        check("rst_flags",     32'({z_out, v_out, n_out}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        do_op("add_sat_pos",  16'h7FFF, 16'h0001, 2'b00, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        do_op("add_sat_neg",  16'h8000, 16'hFFFF, 2'b00, 16'h8000, 1'b1, 1'b1, 1'b0);
        do_op("sub_sat_neg",  16'h8000, 16'h0001, 2'b01, 16'h8000, 1'b1, 1'b1, 1'b0);
        do_op("sub_sat_pos",  16'h7FFF, 16'hFFFF, 2'b01, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        do_op("sub_zero",     16'h0005, 16'h0005, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op("wrap_zero",    16'hFFFF, 16'h0001, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op("wrap_ovf",     16'h7FFF, 16'h0001, 2'b11, 16'h8000, 1'b1, 1'b1, 1'b0);
        do_op("paddsb",       16'h783F, 16'h1F41, 2'b10, 16'h7870, 1'b1, 1'b0, 1'b0);
        do_op("add_plain",    16'h1234, 16'h0F0F, 2'b00, 16'h2143, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream with a three-cycle output stall.
        for (int i = 0; i < 6; i++) begin
            va[i]  = 16'($urandom);
            vb[i]  = 16'($urandom);
            vop[i] = 2'($urandom_range(0, 3));
        end
        sent = 0; recv = 0; max_inflight = 0; saw_low = 0; prev_stall = 0;
        prev_res = '0; prev_flags = '0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 6);
            a_in      = (sent < 6) ? va[sent]  : 16'h0;
            b_in      = (sent < 6) ? vb[sent]  : 16'h0;
            op_in     = (sent < 6) ? vop[sent] : 2'b00;
            @(negedge clk);
            if (prev_stall) begin
                check("stall_hold_res",   32'(result_out), 32'(prev_res));
                check("stall_hold_flags", 32'({z_out, v_out, n_out}), 32'(prev_flags));
            end
            if (!out_ready && !in_ready) saw_low = 1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                if (expq.size() == 0) begin
                    check("stream_spurious", 32'(out_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("stream_res", 32'(result_out), 32'(e[15:0]));
                    check("stream_v",   32'(v_out), 32'(e[16]));
                    recv++;
                end
            end
            if (acc) begin
                expq.push_back(model(a_in, b_in, op_in));
                sent++;
            end
            if (sent - recv > max_inflight) max_inflight = sent - recv;
            prev_stall = out_valid && !out_ready;
            prev_res   = result_out;
            prev_flags = {z_out, v_out, n_out};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_recv",         32'(recv), 32'd6);
        check("stream_in_ready_low", 32'(saw_low), 32'd1);
        check("stream_max_inflight", 32'(max_inflight), 32'd2);

        // Fill both stages, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        a_in = 16'h0100; b_in = 16'h0200; op_in = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 a_in = 16'h0300; b_in = 16'h0400;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("flight_out_valid", 32'(out_valid), 32'd1);
        check("flight_in_ready",  32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",  32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result_out), 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
